mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline: consumes the EX/MEM register fields, performs word loads/stores on an external data memory through a req/ack handshake, resolves branches, and drives the MEM/WB register.
- Stalls the upstream pipeline while a memory transaction is outstanding.
- Aborts a transaction that exceeds a cycle budget, and flags misaligned accesses.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mem_timeout_ctr.sv | 35 +++
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: field widths, EX/MEM
// control-bit positions and the MEM stage state encoding.
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;
    localparam int CTRL_W = 6;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an outstanding memory access; tc_o flags the
// last cycle the access may wait before it is abandoned.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a req/ack data-memory port,
// branch resolution and the MEM/WB register.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic [WORD_W-1:0] ex_alu,
    input  logic [WORD_W-1:0] ex_rt,
    input  logic              ex_zero,
    input  logic [WORD_W-1:0] ex_btarget,
    output logic              stall,
    output logic              pc_src,
    output logic [WORD_W-1:0] pc_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  wb_dest,
    output logic [WORD_W-1:0] wb_alu,
    output logic [WORD_W-1:0] wb_mem_data,
    output logic              mem_err,
    output logic [WORD_W-1:0] err_addr
);

    mem_state_e state_q, state_d;

    logic              req_q, req_d, we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [REG_W-1:0]  ldest_q, ldest_d;
    logic              lrw_q, lrw_d, lm2r_q, lm2r_d;
    logic              wv_q, wv_d, wrw_q, wrw_d, wm2r_q, wm2r_d;
    logic [REG_W-1:0]  wdest_q, wdest_d;
    logic [WORD_W-1:0] walu_q, walu_d, wmd_q, wmd_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] eaddr_q, eaddr_d;

    logic is_mem, misal, start, in_access, tc;
    logic unused_ctrl;

    assign unused_ctrl = ex_ctrl[5];
    assign is_mem      = ex_ctrl[CTRL_MEMREAD] | ex_ctrl[CTRL_MEMWRITE];
    assign misal       = (ex_alu[1:0] != 2'b00);
    assign start       = (state_q == ST_IDLE) && ex_valid && is_mem && !misal;
    assign in_access   = (state_q == ST_ACCESS);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_ctr (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (!in_access),
        .en_i    (in_access),
        .tc_o    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCESS;
            ST_ACCESS: if (dmem_ack || tc) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Stall covers the issuing cycle too, before the FSM has left IDLE.
    always_comb begin
        stall     = start || in_access;
        pc_src    = 1'b0;
        pc_target = '0;
        if (state_q == ST_IDLE) begin
            pc_src    = ex_valid & ex_ctrl[CTRL_BRANCH] & ex_zero;
            pc_target = ex_btarget;
        end
    end

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ldest_d = ldest_q;
        lrw_d   = lrw_q;
        lm2r_d  = lm2r_q;
        wv_d    = 1'b0;
        wrw_d   = 1'b0;
        wm2r_d  = 1'b0;
        wdest_d = '0;
        walu_d  = '0;
        wmd_d   = '0;
        err_d   = 1'b0;
        eaddr_d = eaddr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ex_valid && (!is_mem || misal)) begin
                    wv_d    = 1'b1;
                    wrw_d   = ex_ctrl[CTRL_REGWRITE] & !is_mem;
                    wm2r_d  = ex_ctrl[CTRL_MEMTOREG];
                    wdest_d = ex_dest;
                    walu_d  = ex_alu;
                    err_d   = is_mem;
                    if (is_mem) eaddr_d = ex_alu;
                end else if (start) begin
                    req_d   = 1'b1;
                    we_d    = ex_ctrl[CTRL_MEMWRITE];
                    addr_d  = ex_alu;
                    wdata_d = ex_rt;
                    ldest_d = ex_dest;
                    lrw_d   = ex_ctrl[CTRL_REGWRITE] & !ex_ctrl[CTRL_MEMWRITE];
                    lm2r_d  = ex_ctrl[CTRL_MEMTOREG];
                end
            end
            ST_ACCESS: begin
                // An ack on the terminal cycle still completes normally.
                if (dmem_ack || tc) begin
                    req_d   = 1'b0;
                    wv_d    = 1'b1;
                    wrw_d   = lrw_q & dmem_ack;
                    wm2r_d  = lm2r_q;
                    wdest_d = ldest_q;
                    walu_d  = addr_q;
                    wmd_d   = (dmem_ack && !we_q) ? dmem_rdata : '0;
                    err_d   = !dmem_ack;
                    if (!dmem_ack) eaddr_d = addr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldest_q <= '0;
            lrw_q   <= 1'b0;
            lm2r_q  <= 1'b0;
            wv_q    <= 1'b0;
            wrw_q   <= 1'b0;
            wm2r_q  <= 1'b0;
            wdest_q <= '0;
            walu_q  <= '0;
            wmd_q   <= '0;
            err_q   <= 1'b0;
            eaddr_q <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldest_q <= ldest_d;
            lrw_q   <= lrw_d;
            lm2r_q  <= lm2r_d;
            wv_q    <= wv_d;
            wrw_q   <= wrw_d;
            wm2r_q  <= wm2r_d;
            wdest_q <= wdest_d;
            walu_q  <= walu_d;
            wmd_q   <= wmd_d;
            err_q   <= err_d;
            eaddr_q <= eaddr_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wv_q;
    assign wb_reg_write  = wrw_q;
    assign wb_mem_to_reg = wm2r_q;
    assign wb_dest       = wdest_q;
    assign wb_alu        = walu_q;
    assign wb_mem_data   = wmd_q;
    assign mem_err       = err_q;
    assign err_addr      = eaddr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores,
// misalignment, timeout, branch and reset during an access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [5:0]  ex_ctrl;
    logic [4:0]  ex_dest;
    logic [31:0] ex_alu, ex_rt, ex_btarget;
    logic        ex_zero;
    logic        stall, pc_src;
    logic [31:0] pc_target;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_dest;
    logic [31:0] wb_alu, wb_mem_data;
    logic        mem_err;
    logic [31:0] err_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_dest(ex_dest),
        .ex_alu(ex_alu), .ex_rt(ex_rt), .ex_zero(ex_zero),
        .ex_btarget(ex_btarget),
        .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest), .wb_alu(wb_alu),
        .wb_mem_data(wb_mem_data), .mem_err(mem_err), .err_addr(err_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_ctrl = 6'd0; ex_dest = 5'd0;
        ex_alu = 32'd0; ex_rt = 32'd0; ex_zero = 1'b0; ex_btarget = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic issue(input logic [5:0] c, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] rt);
        ex_valid = 1'b1; ex_ctrl = c; ex_dest = d; ex_alu = a; ex_rt = rt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_ex();
        tick(); tick(); settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall); end
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h/%0h exp=0/0", dmem_req, dmem_we); end
        checks++; if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin errors++; $display("FAIL rst_addr got=%h/%h exp=0", dmem_addr, dmem_wdata); end
        checks++; if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest, wb_alu, wb_mem_data} !== 72'd0) begin errors++; $display("FAIL rst_wb got=%0h exp=0", wb_valid); end
        checks++; if (mem_err !== 1'b0 || err_addr !== 32'd0) begin errors++; $display("FAIL rst_err got=%0h/%h exp=0", mem_err, err_addr); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_alu();
        tick();
        issue(6'b000001, 5'd5, 32'h1234, 32'd0);
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall0 got=%0h exp=0", stall); end
        tick();
        clear_ex();
        settle();
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_wb got=%0h/%0h exp=1/1", wb_valid, wb_reg_write); end
        checks++; if (wb_dest !== 5'd5 || wb_alu !== 32'h1234) begin errors++; $display("FAIL alu_data got=%0d/%h exp=5/1234", wb_dest, wb_alu); end
        checks++; if (wb_mem_data !== 32'd0 || wb_mem_to_reg !== 1'b0) begin errors++; $display("FAIL alu_md got=%h/%0h exp=0/0", wb_mem_data, wb_mem_to_reg); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall1 got=%0h exp=0", stall); end
        tick();
        settle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_bubble got=%0h exp=0", wb_valid); end
    endtask

    task automatic test_load();
        int stall_cnt = 0;
        int req_cnt = 0;
        bit done = 0;
        tick();
        issue(6'b001011, 5'd7, 32'h40, 32'd0);
        ex_btarget = 32'h300; ex_zero = 1'b1;
        settle();
        checks++; if (stall !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL ld_issue got=%0h/%0h exp=1/0", stall, dmem_req); end
        if (stall) stall_cnt++;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            tick();
            dmem_ack = 1'b0;
            settle();
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    checks++; if (dmem_addr !== 32'h40 || dmem_we !== 1'b0) begin errors++; $display("FAIL ld_addr got=%h/%0h exp=40/0", dmem_addr, dmem_we); end
                    checks++; if (pc_src !== 1'b0 || pc_target !== 32'd0) begin errors++; $display("FAIL ld_pc got=%0h/%h exp=0/0", pc_src, pc_target); end
                end
                if (req_cnt == 3) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = 32'hDEADBEEF;
                end
            end
            if (wb_valid) begin
                done = 1;
                checks++; if (wb_mem_data !== 32'hDEADBEEF || wb_mem_to_reg !== 1'b1) begin errors++; $display("FAIL ld_data got=%h/%0h exp=deadbeef/1", wb_mem_data, wb_mem_to_reg); end
                checks++; if (wb_reg_write !== 1'b1 || wb_dest !== 5'd7) begin errors++; $display("FAIL ld_dest got=%0h/%0d exp=1/7", wb_reg_write, wb_dest); end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL ld_wait got=no_wb exp=wb_valid"); end
        checks++; if (req_cnt !== 3) begin errors++; $display("FAIL ld_req_cycles got=%0d exp=3", req_cnt); end
        checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL ld_stall_cycles got=%0d exp=4", stall_cnt); end
        tick();
        clear_ex();
        settle();
        checks++; if (wb_valid !== 1'b0 || wb_mem_data !== 32'd0) begin errors++; $display("FAIL ld_bubble got=%0h/%h exp=0/0", wb_valid, wb_mem_data); end
    endtask

    task automatic test_store(input logic [5:0] c, input logic [31:0] a,
                              input logic [31:0] d, input string nm);
        tick();
        issue(c, 5'd9, a, d);
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s_stall got=%0h exp=1", nm, stall); end
        tick();
        settle();
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL %s_req got=%0h/%0h exp=1/1", nm, dmem_req, dmem_we); end
        checks++; if (dmem_addr !== a || dmem_wdata !== d) begin errors++; $display("FAIL %s_bus got=%h/%h exp=%h/%h", nm, dmem_addr, dmem_wdata, a, d); end
        dmem_ack = 1'b1;
        dmem_rdata = 32'h55AA55AA;
        tick();
        dmem_ack = 1'b0;
        settle();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL %s_done got=%0h/%0h exp=0/0", nm, dmem_req, stall); end
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_mem_data !== 32'd0) begin errors++; $display("FAIL %s_wb got=%0h/%0h/%h exp=1/0/0", nm, wb_valid, wb_reg_write, wb_mem_data); end
        tick();
        clear_ex();
    endtask

    task automatic test_misaligned();
        tick();
        issue(6'b001011, 5'd3, 32'h42, 32'd0);
        settle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got=%0h exp=0", stall); end
        tick();
        clear_ex();
        settle();
        checks++; if (dmem_req !== 1'b0 || mem_err !== 1'b1 || err_addr !== 32'h42) begin errors++; $display("FAIL mis_err got=%0h/%0h/%h exp=0/1/42", dmem_req, mem_err, err_addr); end
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin errors++; $display("FAIL mis_wb got=%0h/%0h exp=1/0", wb_valid, wb_reg_write); end
        tick();
        settle();
        checks++; if (mem_err !== 1'b0 || err_addr !== 32'h42) begin errors++; $display("FAIL mis_hold got=%0h/%h exp=0/42", mem_err, err_addr); end
    endtask

    task automatic test_timeout(input int ack_at, input logic [31:0] a, input string nm);
        int req_cnt = 0;
        bit dropped = 0;
        tick();
        issue(6'b001011, 5'd4, a, 32'd0);
        for (int cyc = 0; cyc < 40 && !dropped; cyc++) begin
            tick();
            dmem_ack = 1'b0;
            settle();
            if (dmem_req) begin
                req_cnt++;
                if (req_cnt == ack_at) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = 32'hCAFEF00D;
                end
            end else begin
                dropped = 1;
            end
        end
        checks++; if (!dropped || req_cnt !== 16) begin errors++; $display("FAIL %s_req_cycles got=%0d exp=16", nm, req_cnt); end
        checks++; if (stall !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL %s_release got=%0h/%0h exp=0/1", nm, stall, wb_valid); end
        if (ack_at == 16) begin
            checks++; if (mem_err !== 1'b0 || wb_reg_write !== 1'b1 || wb_mem_data !== 32'hCAFEF00D) begin errors++; $display("FAIL %s_ack got=%0h/%0h/%h exp=0/1/cafef00d", nm, mem_err, wb_reg_write, wb_mem_data); end
        end else begin
            checks++; if (mem_err !== 1'b1 || err_addr !== a || wb_reg_write !== 1'b0) begin errors++; $display("FAIL %s_err got=%0h/%h/%0h exp=1/%h/0", nm, mem_err, err_addr, wb_reg_write, a); end
        end
        tick();
        clear_ex();
        settle();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL %s_pulse got=%0h exp=0", nm, mem_err); end
    endtask

    task automatic test_branch();
        tick();
        ex_valid = 1'b1; ex_ctrl = 6'b000100; ex_zero = 1'b1; ex_btarget = 32'h100;
        settle();
        checks++; if (pc_src !== 1'b1 || pc_target !== 32'h100) begin errors++; $display("FAIL br_taken got=%0h/%h exp=1/100", pc_src, pc_target); end
        ex_zero = 1'b0;
        #1;
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL br_not_taken got=%0h exp=0", pc_src); end
        tick();
        clear_ex();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12345678;
        tick();
        dmem_ack = 1'b0;
        settle();
        checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || wb_mem_data !== 32'd0) begin errors++; $display("FAIL idle_ack got=%0h/%0h/%h exp=0/0/0", dmem_req, wb_valid, wb_mem_data); end
    endtask

    task automatic test_reset_mid_access();
        tick();
        issue(6'b001011, 5'd6, 32'h70, 32'd0);
        tick();
        settle();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rma_req got=%0h exp=1", dmem_req); end
        reset = 1'b1;
        tick();
        clear_ex();
        settle();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 || mem_err !== 1'b0 || err_addr !== 32'd0) begin errors++; $display("FAIL rma_clear got=%0h/%0h/%0h/%0h/%h exp=0", dmem_req, stall, wb_valid, mem_err, err_addr); end
        tick();
        reset = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBADBAD00;
        tick();
        dmem_ack = 1'b0;
        settle();
        checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || wb_mem_data !== 32'd0) begin errors++; $display("FAIL rma_late_ack got=%0h/%0h/%h exp=0/0/0", wb_valid, dmem_req, wb_mem_data); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store(6'b010000, 32'h80, 32'hA5A5A5A5, "st");
        test_store(6'b011011, 32'h84, 32'h00000011, "strd");
        test_misaligned();
        test_timeout(0, 32'h50, "tmo");
        test_timeout(16, 32'h60, "tmoack");
        test_branch();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
